hack_boot_loader: RTL and testbench

- Sequencer that owns the Hack CPU reset and fills the instruction ROM from a byte stream (UART receiver output) before letting the CPU run.
- Holds the CPU in reset, loads a length-prefixed program into ROM words 0..N-1, waits a fixed settle time, then releases reset so execution starts at pc=0.
- A reload request returns to loading without a global reset.
- Sits between the serial receiver, the ROM write port and the CPU reset input.

---
 rtl/hack_boot_loader.sv | 156 +++++++++++++++
 tb/tb_hack_boot_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hack_boot_loader.sv
// rtl/hack_boot_loader.sv - Hack CPU boot loader: fills instruction ROM from a byte stream, then releases CPU reset
module hack_boot_loader #(
    parameter int ADDR_W   = 15,
    parameter int TIMEOUT  = 100000,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              cpu_reset,
    output logic              loaded,
    output logic              error
);

    // One counter serves both the inter-byte timeout and the reset-hold delay.
    localparam int TMAX = (TIMEOUT > RST_HOLD) ? TIMEOUT : RST_HOLD;
    localparam int TW   = $clog2(TMAX) + 1;
    // 17 bits so a full 2**16-word ROM capacity is still representable.
    localparam logic [16:0] CAP = 17'(1 << ADDR_W);

    typedef enum logic [2:0] {
        CNT_H, CNT_L, DAT_H, DAT_L, WRITE, HOLD, RUN, ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       index_q, index_d;
    logic [15:0]       n_q, n_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;

    logic        accept;
    logic [15:0] n_full;

    assign rx_ready  = !reset && (state_q inside {CNT_H, CNT_L, DAT_H, DAT_L});
    assign accept    = rx_valid && rx_ready;
    assign n_full    = {n_q[15:8], rx_data};

    // A reset landing on the WRITE cycle must not let the strobe through.
    assign rom_we    = !reset && (state_q == WRITE);
    assign rom_addr  = addr_q;
    assign rom_data  = data_q;
    assign cpu_reset = reset || (state_q != RUN);
    assign loaded    = (state_q == RUN);
    assign error     = (state_q == ERR);

    // State register and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CNT_H;
            index_q <= '0;
            n_q     <= '0;
            timer_q <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            n_q     <= n_d;
            timer_q <= timer_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic: byte framing, ROM write sequencing, timeout and hold delay.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        n_d     = n_q;
        timer_d = timer_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        data_d  = data_q;

        // Once a transfer has started, a stalled sender eventually aborts it.
        if (state_q inside {CNT_L, DAT_H, DAT_L}) begin
            if (accept) begin
                timer_d = '0;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
                state_d = ERR;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        case (state_q)
            CNT_H: begin
                if (accept) begin
                    n_d[15:8] = rx_data;
                    state_d   = CNT_L;
                end
            end
            CNT_L: begin
                if (accept) begin
                    n_d[7:0] = rx_data;
                    if ({1'b0, n_full} > CAP) begin
                        state_d = ERR;
                    end else if (n_full == 16'd0) begin
                        state_d = HOLD;
                    end else begin
                        state_d = DAT_H;
                    end
                end
            end
            DAT_H: begin
                if (accept) begin
                    hi_d    = rx_data;
                    state_d = DAT_L;
                end
            end
            DAT_L: begin
                if (accept) begin
                    data_d  = {hi_q, rx_data};
                    addr_d  = index_q[ADDR_W-1:0];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                timer_d = '0;
                if (index_q == n_q - 16'd1) begin
                    state_d = HOLD;
                end else begin
                    index_d = index_q + 16'd1;
                    state_d = DAT_H;
                end
            end
            HOLD: begin
                if (timer_q == TW'(RST_HOLD - 1)) begin
                    state_d = RUN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RUN, ERR: begin
                if (load_req) begin
                    state_d = CNT_H;
                    index_d = '0;
                    n_d     = '0;
                    timer_d = '0;
                end
            end
            default: state_d = CNT_H;
        endcase
    end

endmodule

// File: tb/tb_hack_boot_loader.sv
// tb/tb_hack_boot_loader.sv - directed self-checking bench for hack_boot_loader
module tb_hack_boot_loader;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_req;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              cpu_reset;
    logic              loaded;
    logic              error;

    int tests = 0;
    int fails = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [15:0]       wd[$];

    hack_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(8), .RST_HOLD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_req  (load_req),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cpu_reset (cpu_reset),
        .loaded    (loaded),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Record every ROM write, sampled mid-cycle.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            wa.push_back(rom_addr);
            wd.push_back(rom_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until an edge where it is accepted.
    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("send_ready", 32'(n < 20), 32'd1);
        step();
        rx_valid = 1'b0;
    endtask

    // Caller sits in the first cycle of cpu_reset high; check remaining high cycles, then RUN.
    task automatic hold_then_run(input int high_cycles, input string tag);
        for (int i = 0; i < high_cycles; i++) begin
            chk({tag, "_hold"}, 32'(cpu_reset), 32'd1);
            step();
        end
        chk({tag, "_run_rst"}, 32'(cpu_reset), 32'd0);
        chk({tag, "_loaded"}, 32'(loaded), 32'd1);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_req = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        step(); step();
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_rom_we", 32'(rom_we), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_rom_data", 32'(rom_data), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_rx_ready", 32'(rx_ready), 32'd1);

        // Two-word program.
        send(8'h00); send(8'h02); send(8'h30); send(8'h39); send(8'hEC); send(8'h10);
        chk("p1_we_last", 32'(rom_we), 32'd1);
        chk("p1_ready_in_write", 32'(rx_ready), 32'd0);
        step();
        hold_then_run(4, "p1");
        chk("p1_nwrites", 32'(wa.size()), 32'd2);
        chk("p1_a0", 32'(wa[0]), 32'd0);
        chk("p1_d0", 32'(wd[0]), 32'h3039);
        chk("p1_a1", 32'(wa[1]), 32'd1);
        chk("p1_d1", 32'(wd[1]), 32'hEC10);
        chk("p1_run_ready", 32'(rx_ready), 32'd0);
        chk("p1_hold_data", 32'(rom_data), 32'hEC10);

        // Reload from RUN with a byte already valid; it must not be taken on the load edge.
        rx_valid = 1'b1; rx_data = 8'h00; load_req = 1'b1;
        step();
        load_req = 1'b0;
        chk("rl_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rl_loaded", 32'(loaded), 32'd0);
        chk("rl_rx_ready", 32'(rx_ready), 32'd1);
        step();           // count high byte
        step();           // count low byte -> N=0 -> HOLD
        rx_valid = 1'b0;
        hold_then_run(4, "n0");
        chk("n0_nwrites", 32'(wa.size()), 32'd2);

        // Oversized count (17 > 16 words).
        pulse_load();
        send(8'h00); send(8'h11);
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("ovf_rx_ready", 32'(rx_ready), 32'd0);
        chk("ovf_nwrites", 32'(wa.size()), 32'd2);

        // Exactly full ROM (16 words) is legal; then stall mid-word to hit the timeout.
        pulse_load();
        chk("ld_error_clr", 32'(error), 32'd0);
        send(8'h00); send(8'h10);
        chk("cap_no_error", 32'(error), 32'd0);
        send(8'h3F);
        for (int i = 0; i < 8; i++) begin
            chk("to_not_yet", 32'(error), 32'd0);
            step();
        end
        chk("to_error", 32'(error), 32'd1);
        chk("to_nwrites", 32'(wa.size()), 32'd2);

        // Recover and load a single word.
        pulse_load();
        send(8'h00); send(8'h01); send(8'h3F); send(8'hFF);
        chk("p2_we", 32'(rom_we), 32'd1);
        step();
        hold_then_run(4, "p2");
        chk("p2_nwrites", 32'(wa.size()), 32'd3);
        chk("p2_a0", 32'(wa[2]), 32'd0);
        chk("p2_d0", 32'(wd[2]), 32'h3FFF);

        // Reset arriving on the WRITE cycle suppresses the strobe.
        pulse_load();
        send(8'h00); send(8'h01); send(8'hAB); send(8'hCD);
        reset = 1'b1;
        #1;
        chk("rw_we_blocked", 32'(rom_we), 32'd0);
        step();
        chk("rw_rom_addr", 32'(rom_addr), 32'd0);
        chk("rw_rom_data", 32'(rom_data), 32'd0);
        chk("rw_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rw_rx_ready_in_rst", 32'(rx_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rw_rx_ready", 32'(rx_ready), 32'd1);
        chk("rw_nwrites", 32'(wa.size()), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
